// File: rtl/ram_stream_reader.sv
// Read-side controller for dp_ram: turns a (base, length) command into credit-limited RAM
// reads and re-emits the returned words as a valid/ready stream with a last marker.
//
// state | meaning
// FLUSH | after reset, discard responses to reads issued before reset
// IDLE  | accept a command
// RUN   | issue reads and stream the returned words
module ram_stream_reader #(
  parameter int LATENCY    = 2,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int BUF_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_start,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [ADDR_WIDTH:0]   cmd_len,
  output logic                  cmd_ready,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_rd,
  input  logic [DATA_WIDTH-1:0] ram_data,
  input  logic                  ram_data_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  output logic                  m_last,
  input  logic                  m_ready
);

  localparam int CW  = $clog2(BUF_DEPTH + 1);
  localparam int CW1 = CW + 1;
  localparam int PW  = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int LW  = ADDR_WIDTH + 1;
  localparam logic [CW:0]         DEPTH_C = CW1'(BUF_DEPTH);
  localparam logic [PW-1:0]       PTR_MAX = PW'(BUF_DEPTH - 1);
  localparam logic [ADDR_WIDTH:0] LEN_ONE = LW'(1);

  typedef enum logic [1:0] {S_FLUSH, S_IDLE, S_RUN} state_t;

  state_t                state, state_next;
  logic [1:0]            flush_cnt;
  logic [ADDR_WIDTH:0]   issue_left;
  logic [ADDR_WIDTH:0]   beats_left;
  logic [CW-1:0]         inflight;
  logic [CW-1:0]         occupancy;
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [DATA_WIDTH-1:0] buf_mem [BUF_DEPTH];

  logic accept;
  logic push;
  logic pop;
  logic last_beat;
  logic has_credit;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_MAX) ? '0 : p + PW'(1);
  endfunction

  assign accept     = (state == S_IDLE) && cmd_start;
  assign has_credit = ({1'b0, inflight} + {1'b0, occupancy}) < DEPTH_C;
  // Responses are only meaningful in RUN; in FLUSH they belong to reads issued before reset.
  assign push       = (state == S_RUN) && ram_data_valid;
  assign pop        = m_valid && m_ready;
  assign last_beat  = pop && m_last;
  assign m_data     = buf_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) state <= S_FLUSH;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_FLUSH: if (flush_cnt == 2'd0) state_next = S_IDLE;
      S_IDLE:  if (cmd_start && (cmd_len != '0)) state_next = S_RUN;
      S_RUN:   if (last_beat) state_next = S_IDLE;
      default: state_next = S_FLUSH;
    endcase
  end

  always_comb begin
    cmd_ready = (state == S_IDLE);
    ram_rd    = (state == S_RUN) && (issue_left != '0) && has_credit;
    m_valid   = (occupancy != '0);
    m_last    = m_valid && (beats_left == LEN_ONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flush_cnt  <= 2'(LATENCY);
      ram_addr   <= '0;
      issue_left <= '0;
      beats_left <= '0;
      inflight   <= '0;
      occupancy  <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      done       <= 1'b0;
      for (int i = 0; i < BUF_DEPTH; i++) buf_mem[i] <= '0;
    end else begin
      done <= (accept && (cmd_len == '0)) || last_beat;

      if ((state == S_FLUSH) && (flush_cnt != 2'd0)) flush_cnt <= flush_cnt - 2'd1;

      if (accept) begin
        ram_addr   <= cmd_addr;
        issue_left <= cmd_len;
        beats_left <= cmd_len;
      end else begin
        if (ram_rd) begin
          ram_addr   <= ram_addr + ADDR_WIDTH'(1);
          issue_left <= issue_left - LEN_ONE;
        end
        if (pop) beats_left <= beats_left - LEN_ONE;
      end

      inflight  <= inflight + CW'(ram_rd) - CW'(push);
      occupancy <= occupancy + CW'(push) - CW'(pop);

      if (push) begin
        buf_mem[wr_ptr] <= ram_data;
        wr_ptr          <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
    end
  end

endmodule

// File: tb/tb_ram_stream_reader.sv
// Directed bench for ram_stream_reader: a latency-2 RAM model, a table of commands checked
// against an address/data formula, plus hand sequences for reset, zero length and ignored start.
module tb_ram_stream_reader;

  localparam int LAT = 2;
  localparam int AW  = 10;
  localparam int DW  = 32;
  localparam int BD  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_start = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [AW:0]   cmd_len = '0;
  logic          cmd_ready;
  logic          done;
  logic [AW-1:0] ram_addr;
  logic          ram_rd;
  logic [DW-1:0] ram_data;
  logic          ram_data_valid;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_last;
  logic          m_ready = 1'b0;

  ram_stream_reader #(.LATENCY(LAT), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BUF_DEPTH(BD)) dut (
    .clk(clk), .rst(rst), .cmd_start(cmd_start), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .cmd_ready(cmd_ready), .done(done), .ram_addr(ram_addr), .ram_rd(ram_rd),
    .ram_data(ram_data), .ram_data_valid(ram_data_valid), .m_data(m_data),
    .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready)
  );

  always #5 clk = ~clk;

  // RAM model: data for address a is a+0x100, returned LAT cycles after the read
  logic [DW-1:0] mem [1024];
  logic          v1 = 1'b0, v2 = 1'b0;
  logic [DW-1:0] d1 = '0, d2 = '0;
  logic          inject = 1'b0;
  always @(posedge clk) begin
    v1 <= ram_rd;
    d1 <= mem[ram_addr];
    v2 <= v1;
    d2 <= d1;
  end
  assign ram_data       = d2;
  assign ram_data_valid = v2 | inject;

  int duty = 100;
  initial forever begin
    @(posedge clk); #1;
    m_ready = ($urandom_range(0, 99) < duty);
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // monitor
  logic [AW-1:0] rd_q[$];
  logic [DW:0]   beat_q[$];
  int first_rd = -1, first_valid = -1, first_hs = -1, last_hs = -1;
  int issued = 0, popped = 0, max_out = 0, done_cnt = 0, done_cyc = -1, t_acc = 0;
  logic done_rdy = 1'b0;
  logic hold_prev = 1'b0, prev_last = 1'b0;
  logic [DW-1:0] prev_data = '0;

  always @(negedge clk) begin
    if (ram_rd) begin
      rd_q.push_back(ram_addr);
      if (first_rd < 0) first_rd = cyc;
      issued++;
    end
    if (m_valid && first_valid < 0) first_valid = cyc;
    if (m_valid && m_ready) begin
      beat_q.push_back({m_last, m_data});
      if (first_hs < 0) first_hs = cyc;
      last_hs = cyc;
      popped++;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      done_rdy = cmd_ready;
    end
    if (hold_prev)
      chk("hold_stable", {30'd0, m_valid, m_last, m_data}, {30'd0, 1'b1, prev_last, prev_data});
    hold_prev = m_valid && !m_ready && !rst;
    prev_data = m_data;
    prev_last = m_last;
    if (issued - popped > max_out) max_out = issued - popped;
  end

  function automatic logic [DW-1:0] exp_data(input int a, input int k);
    return 32'(((a + k) % 1024) + 256);
  endfunction

  task automatic send_cmd(input int a, input int l);
    int n = 0;
    while (!cmd_ready && n < 2000) begin @(posedge clk); #1; n++; end
    chk("cmd_ready_wait", {63'd0, cmd_ready}, 64'd1);
    rd_q.delete();
    beat_q.delete();
    first_rd = -1; first_valid = -1; first_hs = -1; last_hs = -1;
    issued = 0; popped = 0; max_out = 0; done_cnt = 0; done_cyc = -1;
    cmd_start = 1'b1;
    cmd_addr  = a[AW-1:0];
    cmd_len   = l[AW:0];
    t_acc     = cyc;
    @(posedge clk); #1;
    cmd_start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin @(posedge clk); #1; n++; end
    chk({tag, "_done_seen"}, {63'd0, done_cnt != 0}, 64'd1);
    repeat (3) begin @(posedge clk); #1; end
  endtask

  task automatic verify(input string tag, input int a, input int l);
    int bad_d = 0;
    int bad_a = 0;
    chk({tag, "_beats"}, beat_q.size(), l);
    chk({tag, "_reads"}, rd_q.size(), l);
    for (int k = 0; k < l && k < beat_q.size(); k++)
      if (beat_q[k] !== {(k == l - 1), exp_data(a, k)}) bad_d++;
    for (int k = 0; k < l && k < rd_q.size(); k++)
      if (rd_q[k] !== 10'((a + k) % 1024)) bad_a++;
    chk({tag, "_data_order"}, bad_d, 0);
    chk({tag, "_addr_order"}, bad_a, 0);
    chk({tag, "_credit_le_depth"}, {63'd0, max_out <= BD}, 64'd1);
    chk({tag, "_done_once"}, done_cnt, 1);
  endtask

  task automatic check_flush(input string tag);
    for (int k = 0; k < LAT + 1; k++) begin
      chk($sformatf("%s_flush_ready%0d", tag, k), {63'd0, cmd_ready}, 64'd0);
      @(posedge clk); #1;
    end
    chk({tag, "_ready_after_flush"}, {63'd0, cmd_ready}, 64'd1);
  endtask

  typedef struct {
    int          addr;
    int          len;
    int          duty;
    logic [31:0] first_d;
    logic [31:0] last_d;
  } vec_t;

  initial begin
    vec_t vecs[7];
    logic [31:0] fd, ld;
    string tg;

    vecs = '{
      '{5,    8,    100, 32'h105, 32'h10C},
      '{1022, 4,    100, 32'h4FE, 32'h101},
      '{0,    16,   30,  32'h100, 32'h10F},
      '{100,  1024, 100, 32'h164, 32'h163},
      '{7,    1,    100, 32'h107, 32'h107},
      '{1000, 3,    50,  32'h4E8, 32'h4EA},
      '{1020, 16,   30,  32'h4FC, 32'h10B}
    };
    for (int i = 0; i < 1024; i++) mem[i] = 32'(i + 256);

    repeat (3) begin @(posedge clk); #1; end
    chk("rst_cmd_ready", {63'd0, cmd_ready}, 64'd0);
    chk("rst_done",      {63'd0, done}, 64'd0);
    chk("rst_ram_rd",    {63'd0, ram_rd}, 64'd0);
    chk("rst_ram_addr",  ram_addr, 0);
    chk("rst_m_valid",   {63'd0, m_valid}, 64'd0);
    chk("rst_m_last",    {63'd0, m_last}, 64'd0);
    chk("rst_m_data",    m_data, 0);
    rst = 1'b0;
    check_flush("init");

    for (int i = 0; i < 7; i++) begin
      tg = $sformatf("v%0d", i);
      duty = vecs[i].duty;
      send_cmd(vecs[i].addr, vecs[i].len);
      wait_done(tg, vecs[i].len * 25 + 100);
      verify(tg, vecs[i].addr, vecs[i].len);
      fd = (beat_q.size() > 0) ? beat_q[0][31:0] : 32'hDEADBEEF;
      ld = (beat_q.size() > 0) ? beat_q[beat_q.size() - 1][31:0] : 32'hDEADBEEF;
      chk({tg, "_first_data"}, fd, vecs[i].first_d);
      chk({tg, "_last_data"}, ld, vecs[i].last_d);
      chk({tg, "_lat_first_rd"}, first_rd - t_acc, 1);
      chk({tg, "_lat_first_valid"}, first_valid - t_acc, LAT + 2);
      chk({tg, "_done_after_last"}, done_cyc - last_hs, 1);
      chk({tg, "_ready_with_done"}, {63'd0, done_rdy}, 64'd1);
      if (vecs[i].duty == 100) chk({tg, "_no_bubbles"}, last_hs - first_hs, vecs[i].len - 1);
    end

    // zero length: done next cycle, nothing else
    duty = 100;
    send_cmd(50, 0);
    repeat (4) begin @(posedge clk); #1; end
    chk("zero_done_once", done_cnt, 1);
    chk("zero_done_time", done_cyc - t_acc, 1);
    chk("zero_no_reads", issued, 0);
    chk("zero_no_valid", first_valid, -1);
    chk("zero_ready_with_done", {63'd0, done_rdy}, 64'd1);

    // start during RUN must be ignored
    send_cmd(40, 10);
    @(posedge clk); #1;
    cmd_start = 1'b1; cmd_addr = 10'd600; cmd_len = 11'd3;
    @(posedge clk); #1;
    cmd_start = 1'b0;
    wait_done("ign", 400);
    verify("ign", 40, 10);

    // stale response while idle must not enter the buffer
    inject = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk($sformatf("idle_inject_valid%0d", k), {63'd0, m_valid}, 64'd0);
    end
    inject = 1'b0;

    // reset while reads are in flight and the buffer holds words
    duty = 0;
    repeat (2) begin @(posedge clk); #1; end
    send_cmd(200, 16);
    repeat (4) begin @(posedge clk); #1; end
    chk("pre_rst_valid", {63'd0, m_valid}, 64'd1);
    chk("pre_rst_data", m_data, 32'h1C8);
    chk("bp_reads_stop", issued, BD);
    rst = 1'b1;
    duty = 100;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_m_valid", {63'd0, m_valid}, 64'd0);
    chk("mid_rst_m_last", {63'd0, m_last}, 64'd0);
    chk("mid_rst_m_data", m_data, 0);
    chk("mid_rst_ram_rd", {63'd0, ram_rd}, 64'd0);
    inject = 1'b1;
    check_flush("mid");
    inject = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("mid_no_beats", popped, 0);
    chk("mid_no_done", done_cnt, 0);
    chk("mid_idle_empty", {63'd0, m_valid}, 64'd0);
    send_cmd(300, 5);
    wait_done("post_rst", 200);
    verify("post_rst", 300, 5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got cycle %0d required completion", cyc);
    $fatal(1, "timeout");
  end

endmodule
